subbytes_pipe: RTL and testbench

Pipelined, flow-controlled AES SubBytes / InvSubBytes unit with a parametrised lane count and pipeline depth. It replaces the purely combinational 4×32-bit substitution stage in the round datapath. It accepts one state word per handshake and carries a per-beat encrypt/decrypt mode alongside the data, so forward and inverse beats can be freely interleaved. It sits between AddRoundKey and ShiftRows and honours backpressure from the downstream stage.

---
 rtl/aes_pkg.sv | 51 +++++
 rtl/aes_sbox_byte.sv | 12 +
 rtl/subbytes_pipe.sv | 123 ++++++++++++
 tb/tb_subbytes_pipe.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES byte-substitution tables and lane helpers, reused by the round datapath.
package aes_pkg;

    typedef logic [7:0] byte_t;

    localparam int MAX_NBYTES = 32;

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Lane i of a state word occupies bits [lane_lsb(i)+7 : lane_lsb(i)].
    function automatic int lane_lsb(input int lane);
        return 8 * lane;
    endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// Single-byte forward/inverse S-box lookup, purely combinational.
module aes_sbox_byte
    import aes_pkg::*;
(
    input  logic       encode,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = encode ? SBOX[din] : INV_SBOX[din];

endmodule

// File: rtl/subbytes_pipe.sv
// Elastic SubBytes/InvSubBytes pipeline (1 or 2 stages) with per-beat mode and flush.
module subbytes_pipe
    import aes_pkg::*;
#(
    parameter int NBYTES  = 16,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_encode,
    input  logic [8*NBYTES-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_encode,
    output logic [8*NBYTES-1:0] out_data,
    output logic                busy
);

    localparam int W = 8 * NBYTES;

    if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
        $error("subbytes_pipe: LATENCY must be 1 or 2");
    end
    if (NBYTES < 1 || NBYTES > MAX_NBYTES) begin : g_bad_nbytes
        $error("subbytes_pipe: NBYTES must be 1..32");
    end

    logic [W-1:0] sub_in;
    logic [W-1:0] sub_out;
    logic         sub_enc;

    for (genvar i = 0; i < NBYTES; i++) begin : g_lane
        aes_sbox_byte u_sbox (
            .encode (sub_enc),
            .din    (sub_in[lane_lsb(i) +: 8]),
            .dout   (sub_out[lane_lsb(i) +: 8])
        );
    end

    if (LATENCY == 1) begin : g_lat1
        // Lookup in front of the only register: out_data is the registered result.
        logic         v0;
        logic         e0;
        logic [W-1:0] d0;
        logic         rdy0;

        assign sub_in  = in_data;
        assign sub_enc = in_encode;
        assign rdy0    = !v0 || out_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v0 <= 1'b0;
                e0 <= 1'b0;
                d0 <= '0;
            end else if (flush) begin
                v0 <= 1'b0;
            end else if (rdy0) begin
                v0 <= in_valid;
                if (in_valid) begin
                    e0 <= in_encode;
                    d0 <= sub_out;
                end
            end
        end

        assign in_ready   = !flush && rdy0;
        assign out_valid  = v0;
        assign out_encode = e0;
        assign out_data   = d0;
        assign busy       = v0;
    end else begin : g_lat2
        // Stage 0 holds the raw beat; the lookup sits between stage 0 and stage 1.
        logic         v0, v1;
        logic         e0, e1;
        logic [W-1:0] d0, d1;
        logic         rdy0, rdy1;

        assign sub_in  = d0;
        assign sub_enc = e0;
        assign rdy1    = !v1 || out_ready;
        assign rdy0    = !v0 || rdy1;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v0 <= 1'b0;
                e0 <= 1'b0;
                d0 <= '0;
                v1 <= 1'b0;
                e1 <= 1'b0;
                d1 <= '0;
            end else if (flush) begin
                v0 <= 1'b0;
                v1 <= 1'b0;
            end else begin
                if (rdy1) begin
                    v1 <= v0;
                    if (v0) begin
                        e1 <= e0;
                        d1 <= sub_out;
                    end
                end
                if (rdy0) begin
                    v0 <= in_valid;
                    if (in_valid) begin
                        e0 <= in_encode;
                        d0 <= in_data;
                    end
                end
            end
        end

        assign in_ready   = !flush && rdy0;
        assign out_valid  = v1;
        assign out_encode = e1;
        assign out_data   = d1;
        assign busy       = v0 | v1;
    end

endmodule

// File: tb/tb_subbytes_pipe.sv
// Self-checking bench: LATENCY=1 and LATENCY=2 instances against a GF(2^8)-derived S-box model.
module tb_subbytes_pipe;

    typedef logic [128:0] beat_t;

    typedef struct {
        string        name;
        logic         enc;
        logic [127:0] din;
        logic [127:0] dexp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush [2];
    logic         in_valid [2];
    logic         in_ready [2];
    logic         in_encode [2];
    logic [127:0] in_data [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic         out_encode [2];
    logic [127:0] out_data [2];
    logic         busy [2];

    logic [7:0] fwd [256];
    logic [7:0] inv [256];

    int    n_cmp = 0;
    int    n_bad = 0;
    beat_t q0 [$];
    beat_t q1 [$];
    int    accepts [2] = '{0, 0};
    int    pops [2] = '{0, 0};
    logic  stalled [2] = '{1'b0, 1'b0};
    beat_t held [2];

    always #5 clk = ~clk;

    subbytes_pipe #(.NBYTES(16), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_encode(in_encode[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_encode(out_encode[0]), .out_data(out_data[0]),
        .busy(busy[0])
    );

    subbytes_pipe #(.NBYTES(16), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_encode(in_encode[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_encode(out_encode[1]), .out_data(out_data[1]),
        .busy(busy[1])
    );

    task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box = affine transform of the multiplicative inverse in GF(2^8); inverse table by inversion.
    task automatic build_tables();
        logic [7:0] xi;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            xi = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) xi = 8'(y);
            s = xi ^ rotl(xi, 1) ^ rotl(xi, 2) ^ rotl(xi, 3) ^ rotl(xi, 4) ^ 8'h63;
            fwd[x] = s;
            inv[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic enc, input logic [127:0] d);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = enc ? fwd[d[8*i +: 8]] : inv[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int q_size(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    task automatic q_push(input int u, input beat_t b);
        if (u == 0) q0.push_back(b);
        else q1.push_back(b);
    endtask

    task automatic q_pop(input int u, output beat_t b);
        if (u == 0) b = q0.pop_front();
        else b = q1.pop_front();
    endtask

    task automatic q_clear(input int u);
        if (u == 0) q0.delete();
        else q1.delete();
    endtask

    // Scoreboard: inputs only change in the first half of a cycle, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        beat_t b;
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                q_clear(u);
                stalled[u] = 1'b0;
            end else begin
                if (stalled[u]) begin
                    check("stall_hold_valid", 129'(out_valid[u]), 129'(1));
                    check("stall_hold_data", {out_encode[u], out_data[u]}, held[u]);
                end
                if (out_valid[u] && out_ready[u]) begin
                    check("sb_beat_expected", 129'(q_size(u) != 0), 129'(1));
                    if (q_size(u) != 0) begin
                        q_pop(u, b);
                        check("sb_beat", {out_encode[u], out_data[u]}, b);
                    end
                    pops[u]++;
                end
                if (in_valid[u] && in_ready[u]) begin
                    q_push(u, {in_encode[u], model(in_encode[u], in_data[u])});
                    accepts[u]++;
                end
                stalled[u] = out_valid[u] && !out_ready[u] && !flush[u];
                held[u]    = {out_encode[u], out_data[u]};
                if (flush[u]) q_clear(u);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int u, input string name, input logic enc,
                           input logic [127:0] din, input logic [127:0] dexp);
        tick();
        in_valid[u]  = 1'b1;
        in_encode[u] = enc;
        in_data[u]   = din;
        out_ready[u] = 1'b1;
        @(negedge clk);
        check({name, "_in_ready"}, 129'(in_ready[u]), 129'(1));
        tick();
        in_valid[u] = 1'b0;
        if (u == 1) begin
            @(negedge clk);
            check({name, "_not_early"}, 129'(out_valid[u]), 129'(0));
            tick();
        end
        @(negedge clk);
        check({name, "_valid"}, 129'(out_valid[u]), 129'(1));
        check({name, "_data"}, 129'(out_data[u]), 129'(dexp));
        check({name, "_encode"}, 129'(out_encode[u]), 129'(enc));
    endtask

    task automatic backpressure(input int u);
        int         acc;
        logic [7:0] bv;
        acc = 0;
        out_ready[u] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            bv = 8'(acc + 64);
            in_valid[u]  = 1'b1;
            in_encode[u] = acc[0];
            in_data[u]   = {16{bv}};
            @(negedge clk);
            if (in_ready[u]) acc++;
        end
        check("bp_accepted", 129'(acc), 129'(u + 1));
        check("bp_in_ready_low", 129'(in_ready[u]), 129'(0));
        check("bp_busy", 129'(busy[u]), 129'(1));
        tick();
        in_valid[u] = 1'b0;
        #1 out_ready[u] = 1'b1;
        #1 check("bp_in_ready_rise", 129'(in_ready[u]), 129'(1));
        repeat (4) tick();
        check("bp_drained", 129'(busy[u]), 129'(0));
    endtask

    task automatic flush_test(input int u);
        logic [127:0] d;
        out_ready[u] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            in_valid[u]  = 1'b1;
            in_encode[u] = 1'($urandom_range(1));
            in_data[u]   = rand128();
        end
        @(negedge clk);
        check("flush_pre_busy", 129'(busy[u]), 129'(1));
        tick();
        in_data[u]   = rand128();
        flush[u]     = 1'b1;
        out_ready[u] = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 129'(in_ready[u]), 129'(0));
        tick();
        flush[u]    = 1'b0;
        in_valid[u] = 1'b0;
        check("flush_out_valid", 129'(out_valid[u]), 129'(0));
        check("flush_busy", 129'(busy[u]), 129'(0));
        d = rand128();
        run_vec(u, "flush_next", 1'b1, d, model(1'b1, d));
    endtask

    initial begin
        vec_t         vt [8];
        logic [7:0]   il_in [3];
        logic [7:0]   il_exp [3];
        logic         il_enc [3];
        logic [127:0] bd [3];
        logic         took [2];
        logic [127:0] d;

        build_tables();
        for (int u = 0; u < 2; u++) begin
            flush[u] = 1'b0; in_valid[u] = 1'b0; in_encode[u] = 1'b0;
            in_data[u] = '0; out_ready[u] = 1'b0; took[u] = 1'b0;
        end

        #12;
        for (int u = 0; u < 2; u++) begin
            check("rst_out_valid", 129'(out_valid[u]), 129'(0));
            check("rst_busy", 129'(busy[u]), 129'(0));
            check("rst_out_data", 129'(out_data[u]), 129'(0));
            check("rst_out_encode", 129'(out_encode[u]), 129'(0));
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        for (int u = 0; u < 2; u++) check("rst_in_ready", 129'(in_ready[u]), 129'(1));

        vt[0] = '{"fwd_0to15", 1'b1, 128'h0f0e0d0c0b0a09080706050403020100, 128'h76abd7fe2b670130c56f6bf27b777c63};
        vt[1] = '{"inv_roundtrip", 1'b0, 128'h76abd7fe2b670130c56f6bf27b777c63, 128'h0f0e0d0c0b0a09080706050403020100};
        vt[2] = '{"fwd_53", 1'b1, {16{8'h53}}, {16{8'hed}}};
        vt[3] = '{"inv_ed", 1'b0, {16{8'hed}}, {16{8'h53}}};
        for (int k = 4; k < 8; k++) begin
            d = rand128();
            vt[k] = '{"model_vec", k[0], d, model(k[0], d)};
        end
        for (int u = 0; u < 2; u++)
            for (int k = 0; k < 8; k++)
                run_vec(u, vt[k].name, vt[k].enc, vt[k].din, vt[k].dexp);

        il_in  = '{8'h00, 8'h63, 8'hff};
        il_enc = '{1'b1, 1'b0, 1'b1};
        il_exp = '{8'h63, 8'h00, 8'h16};
        for (int c = 0; c < 3; c++) begin
            d = rand128();
            bd[c] = {d[127:8], il_in[c]};
        end
        out_ready[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c < 3) begin
                in_valid[1]  = 1'b1;
                in_encode[1] = il_enc[c];
                in_data[1]   = bd[c];
            end else begin
                in_valid[1] = 1'b0;
            end
            @(negedge clk);
            if (c >= 2) begin
                check("il_valid", 129'(out_valid[1]), 129'(1));
                check("il_lane0", 129'(out_data[1][7:0]), 129'(il_exp[c-2]));
                check("il_encode", 129'(out_encode[1]), 129'(il_enc[c-2]));
            end
        end

        backpressure(0);
        backpressure(1);
        flush_test(0);
        flush_test(1);

        tick();
        accepts[0] = 0; accepts[1] = 0; pops[0] = 0; pops[1] = 0;
        for (int cyc = 0; cyc < 8000 && (accepts[0] < 1000 || accepts[1] < 1000); cyc++) begin
            tick();
            for (int u = 0; u < 2; u++) begin
                if (!in_valid[u] || took[u]) begin
                    in_valid[u]  = (accepts[u] < 1000) && ($urandom_range(3) != 0);
                    in_encode[u] = 1'($urandom_range(1));
                    in_data[u]   = rand128();
                end
                out_ready[u] = ($urandom_range(2) != 0);
            end
            @(negedge clk);
            for (int u = 0; u < 2; u++) took[u] = in_valid[u] && in_ready[u];
        end
        tick();
        for (int u = 0; u < 2; u++) begin
            in_valid[u] = 1'b0;
            out_ready[u] = 1'b1;
        end
        for (int c = 0; c < 20 && (busy[0] || busy[1]); c++) tick();
        for (int u = 0; u < 2; u++) begin
            check("rand_beats_done", 129'(accepts[u] >= 1000), 129'(1));
            check("rand_drained", 129'(busy[u]), 129'(0));
            check("rand_no_loss", 129'(pops[u]), 129'(accepts[u]));
        end

        for (int u = 0; u < 2; u++) out_ready[u] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int u = 0; u < 2; u++) begin
                in_valid[u]  = 1'b1;
                in_encode[u] = 1'($urandom_range(1));
                in_data[u]   = rand128();
            end
        end
        tick();
        for (int u = 0; u < 2; u++) in_valid[u] = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) check("pre_reset_valid", 129'(out_valid[u]), 129'(1));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            check("async_rst_out_valid", 129'(out_valid[u]), 129'(0));
            check("async_rst_busy", 129'(busy[u]), 129'(0));
            check("async_rst_out_data", 129'(out_data[u]), 129'(0));
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        for (int u = 0; u < 2; u++) check("post_rst_in_ready", 129'(in_ready[u]), 129'(1));
        for (int u = 0; u < 2; u++) begin
            d = rand128();
            run_vec(u, "post_rst", 1'b0, d, model(1'b0, d));
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
